// File: rtl/tone_generator.sv
// Square-wave tone generator: plays one divider per note for NOTE_CYCLES,
// then holds silence for GAP_CYCLES, and requests the next divider over valid/ready.
module tone_generator #(
    parameter int DIV_W       = 16,
    parameter int NOTE_CYCLES = 3000000,
    parameter int GAP_CYCLES  = 600000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             speaker,
    output logic             note_done,
    output logic             busy
);
    localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [DIV_W-2:0] HALF_ONE  = (DIV_W-1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] dur_cnt;
    logic [DIV_W-2:0] half;
    logic [DIV_W-2:0] half_cnt;

    // Only the half period matters, so an odd divider rounds down.
    logic unused_div_lsb;
    assign unused_div_lsb = div[0];

    assign div_ready = (state == IDLE) && enable;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            speaker   <= 1'b0;
            note_done <= 1'b0;
            dur_cnt   <= '0;
            half_cnt  <= '0;
            half      <= '0;
        end else if (!enable) begin
            // Abort without signalling completion.
            state     <= IDLE;
            speaker   <= 1'b0;
            note_done <= 1'b0;
            dur_cnt   <= '0;
            half_cnt  <= '0;
        end else begin
            note_done <= 1'b0;
            case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    if (div_valid) begin
                        half     <= div[DIV_W-1:1];
                        dur_cnt  <= '0;
                        half_cnt <= '0;
                        state    <= PLAY;
                    end
                end
                PLAY: begin
                    if (dur_cnt == NOTE_LAST) begin
                        speaker  <= 1'b0;
                        dur_cnt  <= '0;
                        half_cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state     <= IDLE;
                            note_done <= 1'b1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + CNT_ONE;
                        if (half == '0) begin
                            speaker <= 1'b0;
                        end else if (half_cnt == half - HALF_ONE) begin
                            half_cnt <= '0;
                            speaker  <= ~speaker;
                        end else begin
                            half_cnt <= half_cnt + HALF_ONE;
                        end
                    end
                end
                GAP: begin
                    speaker <= 1'b0;
                    if (dur_cnt == GAP_LAST) begin
                        dur_cnt   <= '0;
                        state     <= IDLE;
                        note_done <= 1'b1;
                    end else begin
                        dur_cnt <= dur_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    speaker <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: directed vectors, back-to-back/abort sequences,
// and randomized traffic checked against an arithmetic note-timeline model.
module tb_tone_generator;
    localparam int N  = 40;
    localparam int G  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] div = '0;
    logic        div_valid = 1'b0;
    logic        div_ready, speaker, note_done, busy;
    logic        div_ready_z, speaker_z, note_done_z, busy_z;

    int n_chk  = 0;
    int n_pass = 0;

    tone_generator #(.DIV_W(16), .NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .enable(enable), .div(div), .div_valid(div_valid),
        .div_ready(div_ready), .speaker(speaker), .note_done(note_done), .busy(busy)
    );

    tone_generator #(.DIV_W(16), .NOTE_CYCLES(N), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .enable(enable), .div(div), .div_valid(div_valid),
        .div_ready(div_ready_z), .speaker(speaker_z), .note_done(note_done_z), .busy(busy_z)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Offer one note, then observe it from PLAY entry until note_done.
    task automatic run_note(input logic [15:0] d, output int first_rise,
                            output int rises, output int done_off);
        bit pspk;
        bit entered;
        first_rise = -1; rises = 0; done_off = -1; pspk = 0; entered = 0;
        div = d; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        for (int w = 0; w < 5 && !entered; w++) begin
            if (busy) entered = 1;
            else @(negedge clk);
        end
        if (!entered) return;
        for (int off = 0; off < 80; off++) begin
            if (speaker && !pspk) begin
                rises++;
                if (first_rise < 0) first_rise = off;
            end
            pspk = speaker;
            if (note_done) begin
                done_off = off;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Expected outputs at cycle c for a note whose PLAY begins at st (st<0: none).
    function automatic void model_out(input int st, input int hf, input int g, input int c,
                                      output bit spk, output bit bsy, output bit done);
        int off;
        spk = 0; bsy = 0; done = 0;
        if (st < 0) return;
        off = c - st;
        if (off < 0) return;
        if (off < N) begin
            bsy = 1;
            spk = (hf == 0) ? 1'b0 : bit'((off / hf) % 2);
        end else if (off < N + g) begin
            bsy = 1;
        end else if (off == N + g) begin
            done = 1;
        end
    endfunction

    typedef struct {
        logic [15:0] div;
        int          first_rise;
        int          rises;
        int          done_off;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int fr, rs, dn;
        int entries[4], dones[4], rises_b[4], dz[4];
        int ne, nd, nz;
        bit pbusy, pspk;
        int divs[3];
        int abort_dones;
        bit seen;
        int st[2], hf[2], gp[2];
        bit es, eb, ed;

        vecs[0] = '{16'd8,  4,  5, 48};
        vecs[1] = '{16'd7,  3,  7, 48};
        vecs[2] = '{16'd0, -1,  0, 48};
        vecs[3] = '{16'd1, -1,  0, 48};
        vecs[4] = '{16'd2,  1, 20, 48};
        vecs[5] = '{16'd3,  1, 20, 48};
        vecs[6] = '{16'd10, 5,  4, 48};
        vecs[7] = '{16'd6,  3,  7, 48};

        // Reset with a pending request and enable low.
        div = 16'd8; div_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_speaker", speaker, 0);
        chk("reset_busy", busy, 0);
        chk("reset_div_ready", div_ready, 0);
        chk("reset_note_done", note_done, 0);
        rst = 1'b1; enable = 1'b1;
        #1;
        chk("release_div_ready", div_ready, 1);
        @(negedge clk);
        div_valid = 1'b0;
        chk("first_accept_busy", busy, 1);
        seen = 0;
        for (int w = 0; w < 100 && !seen; w++) begin
            @(negedge clk);
            if (note_done) seen = 1;
        end
        chk("first_note_done_seen", seen, 1);

        foreach (vecs[i]) begin
            run_note(vecs[i].div, fr, rs, dn);
            chk($sformatf("vec%0d_div%0d_first_rise", i, vecs[i].div), fr, vecs[i].first_rise);
            chk($sformatf("vec%0d_div%0d_rises", i, vecs[i].div), rs, vecs[i].rises);
            chk($sformatf("vec%0d_div%0d_done_off", i, vecs[i].div), dn, vecs[i].done_off);
        end

        // Back-to-back 8,6,10 with mid-note div churn; GAP=0 instance runs alongside.
        div_valid = 1'b0;
        do_reset();
        divs[0] = 8; divs[1] = 6; divs[2] = 10;
        ne = 0; nd = 0; nz = 0; pbusy = 0; pspk = 0;
        foreach (entries[i]) begin entries[i] = 0; dones[i] = 0; rises_b[i] = 0; dz[i] = 0; end
        div = 16'd8; div_valid = 1'b1;
        for (int t = 0; t < 220; t++) begin
            if (busy && !pbusy && ne < 4) begin entries[ne] = t; ne++; end
            if (speaker && !pspk && ne > 0) rises_b[ne-1]++;
            if (note_done && nd < 4) begin dones[nd] = t; nd++; end
            if (note_done_z && nz < 4) begin dz[nz] = t; nz++; end
            pbusy = busy; pspk = speaker;
            if (ne > 0) begin
                if (t - entries[ne-1] == 5) div = 16'd2;
                if (t - entries[ne-1] == 30) div = (ne < 3) ? 16'(divs[ne]) : 16'd8;
                if (ne == 3 && t - entries[ne-1] == 1) div_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_note_count", nd, 3);
        chk("b2b_spacing_1", dones[1] - dones[0], 49);
        chk("b2b_spacing_2", dones[2] - dones[1], 49);
        chk("b2b_idle_gap_1", entries[1] - dones[0], 1);
        chk("b2b_idle_gap_2", entries[2] - dones[1], 1);
        chk("b2b_rises_div8", rises_b[0], 5);
        chk("b2b_rises_div6", rises_b[1], 7);
        chk("b2b_rises_div10", rises_b[2], 4);
        chk("gap0_done_off", dz[0] - entries[0], 40);
        chk("gap0_repeat", dz[1] - dz[0], 41);

        // Drop enable at PLAY cycle 10.
        div_valid = 1'b0;
        do_reset();
        div = 16'd8; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        chk("abort_entry_busy", busy, 1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        #1;
        chk("abort_div_ready_low", div_ready, 0);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_speaker", speaker, 0);
        chk("abort_note_done", note_done, 0);
        abort_dones = 0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (note_done || busy) abort_dones++;
        end
        chk("abort_no_done_later", abort_dones, 0);
        enable = 1'b1;

        // Asynchronous reset at GAP cycle 3, then a full note.
        div = 16'd8; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        repeat (43) @(negedge clk);
        chk("gap3_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_speaker", speaker, 0);
        chk("async_rst_note_done", note_done, 0);
        @(negedge clk);
        rst = 1'b1;
        run_note(16'd8, fr, rs, dn);
        chk("restart_first_rise", fr, 4);
        chk("restart_rises", rs, 5);
        chk("restart_done_off", dn, 48);

        // Randomized traffic on both instances against the timeline model.
        div_valid = 1'b0; enable = 1'b1;
        do_reset();
        gp[0] = G; gp[1] = 0;
        st[0] = -1; st[1] = -1; hf[0] = 0; hf[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            bit idle_now[2];
            int r;
            for (int m = 0; m < 2; m++) begin
                model_out(st[m], hf[m], gp[m], c, es, eb, ed);
                idle_now[m] = !eb;
                if (m == 0) begin
                    chk("rand_speaker", speaker, es);
                    chk("rand_busy", busy, eb);
                    chk("rand_note_done", note_done, ed);
                    chk("rand_div_ready", div_ready, !eb && enable);
                end else begin
                    chk("rand_gap0_speaker", speaker_z, es);
                    chk("rand_gap0_busy", busy_z, eb);
                    chk("rand_gap0_note_done", note_done_z, ed);
                    chk("rand_gap0_div_ready", div_ready_z, !eb && enable);
                end
            end
            enable    = ($urandom_range(0, 79) != 0);
            div_valid = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            if (r < 2)      div = 16'(r);
            else if (r < 3) div = 16'($urandom_range(2, 3));
            else if (r < 9) div = 16'($urandom_range(4, 24));
            else            div = 16'($urandom);
            for (int m = 0; m < 2; m++) begin
                if (!enable) st[m] = -1;
                else if (idle_now[m] && div_valid) begin
                    st[m] = c + 1;
                    hf[m] = int'(div) / 2;
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
